// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI constants, FSM state type and transfer-size helper
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY      = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WADDR = 3'd3,
        ST_WDATA = 3'd4,
        ST_WRESP = 3'd5
    } state_e;

    // AxSIZE encoding is log2 of the bytes per beat
    function automatic logic [2:0] size_from_width(input int unsigned width);
        return 3'($clog2(width / 8));
    endfunction

endpackage

// File: rtl/axi_beat_counter.sv
// rtl/axi_beat_counter.sv - beat counter with clear/increment and last-beat compare
module axi_beat_counter #(
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 inc_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    output logic                 is_last_o
);

    logic [LEN_WIDTH-1:0] cnt_q;

    // count accepted beats; clear wins so a new burst always starts at beat 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign is_last_o = (cnt_q == len_i);

endmodule

// File: rtl/axi_burst_master.sv
// rtl/axi_burst_master.sv - one-outstanding request to AXI4 INCR burst initiator; option AXI_BURST_MASTER_LAST_CHK_EN
module axi_burst_master
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  done,
    output logic                  err,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [LEN_WIDTH-1:0]  ARLEN,
    output logic [2:0]            ARSIZE,
    output logic [1:0]            ARBURST,
    input  logic                  RVALID,
    output logic                  RREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic                  RLAST,
    input  logic [1:0]            RRESP,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [LEN_WIDTH-1:0]  AWLEN,
    output logic [2:0]            AWSIZE,
    output logic [1:0]            AWBURST,
    output logic                  WVALID,
    input  logic                  WREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WLAST,
    input  logic                  BVALID,
    output logic                  BREADY,
    input  logic                  BRESP
);

    localparam logic [2:0] AXSIZE = size_from_width(DATA_WIDTH);

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LEN_WIDTH-1:0]    len_q;
    logic                    err_acc_q;
    logic                    done_q;
    logic                    err_q;

    logic in_rdata, in_wdata, in_wresp;
    logic r_hs, w_hs, b_hs;
    logic r_end, r_beat_err;
    logic cnt_clear, cnt_inc, cnt_last;
    logic err_d;

    assign in_rdata  = (state_q == ST_RDATA);
    assign in_wdata  = (state_q == ST_WDATA);
    assign in_wresp  = (state_q == ST_WRESP);
    assign req_ready = (state_q == ST_IDLE);

    assign r_hs = in_rdata & RVALID & rd_ready;
    assign w_hs = in_wdata & wr_valid & WREADY;
    assign b_hs = in_wresp & BVALID;

    assign cnt_clear = req_ready & req_valid;

`ifdef AXI_BURST_MASTER_LAST_CHK_EN
    // the counter owns termination; any disagreement with the slave's RLAST is an error
    assign cnt_inc    = w_hs | r_hs;
    assign r_end      = r_hs & cnt_last;
    assign r_beat_err = (RRESP != RESP_OKAY) | (RLAST != cnt_last);
`else
    // trust the slave's RLAST; the counter only tracks write beats
    assign cnt_inc    = w_hs;
    assign r_end      = r_hs & RLAST;
    assign r_beat_err = (RRESP != RESP_OKAY);
`endif

    assign err_d = err_acc_q | (r_hs & r_beat_err) | (b_hs & BRESP);

    axi_beat_counter #(
        .LEN_WIDTH (LEN_WIDTH)
    ) u_beat_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (cnt_clear),
        .inc_i     (cnt_inc),
        .len_i     (len_q),
        .is_last_o (cnt_last)
    );

    // transaction sequencing, request latching, error accumulation and completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            err_acc_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_acc_q <= err_d;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        len_q     <= req_len;
                        err_acc_q <= 1'b0;
                        state_q   <= req_write ? ST_WADDR : ST_RADDR;
                    end
                end
                ST_RADDR: if (ARREADY) state_q <= ST_RDATA;
                ST_RDATA: begin
                    if (r_end) begin
                        done_q  <= 1'b1;
                        err_q   <= err_d;
                        state_q <= ST_IDLE;
                    end
                end
                ST_WADDR: if (AWREADY) state_q <= ST_WDATA;
                ST_WDATA: if (w_hs && cnt_last) state_q <= ST_WRESP;
                ST_WRESP: begin
                    if (b_hs) begin
                        done_q  <= 1'b1;
                        err_q   <= err_d;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign done    = done_q;
    assign err     = err_q;

    assign ARVALID = (state_q == ST_RADDR);
    assign ARADDR  = addr_q;
    assign ARLEN   = len_q;
    assign ARSIZE  = AXSIZE;
    assign ARBURST = AXI_BURST_INCR;

    assign AWVALID = (state_q == ST_WADDR);
    assign AWADDR  = addr_q;
    assign AWLEN   = len_q;
    assign AWSIZE  = AXSIZE;
    assign AWBURST = AXI_BURST_INCR;

    assign RREADY   = in_rdata & rd_ready;
    assign rd_valid = in_rdata & RVALID;
    assign rd_data  = RDATA;
    assign rd_last  = in_rdata & RLAST;

    assign WVALID   = in_wdata & wr_valid;
    assign WDATA    = wr_data;
    assign WLAST    = in_wdata & cnt_last;
    assign wr_ready = in_wdata & WREADY;

    assign BREADY   = in_wresp;

endmodule

// File: tb/tb_axi_burst_master.sv
// tb/tb_axi_burst_master.sv - directed self-checking bench for axi_burst_master
module tb_axi_burst_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready, rd_last;
    logic [31:0] rd_data;
    logic        done, err;
    logic        ARVALID, ARREADY;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        RVALID, RREADY, RLAST;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        AWVALID, AWREADY;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        WVALID, WREADY, WLAST;
    logic [31:0] WDATA;
    logic        BVALID, BREADY, BRESP;

    int passed = 0;
    int total  = 0;

    axi_burst_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .err(err),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RLAST(RLAST), .RRESP(RRESP),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN),
        .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        req_valid = 0; req_write = 0; req_addr = '0; req_len = '0;
        wr_valid = 0; wr_data = '0; rd_ready = 0;
        ARREADY = 0; RVALID = 0; RDATA = '0; RLAST = 0; RRESP = 2'b00;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        RVALID = 1; BVALID = 1; WREADY = 1; rd_ready = 1;
        @(negedge clk); @(negedge clk);
        total++;
        if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b exp 1", req_ready);
        else passed++;
        total++;
        if ({ARVALID, AWVALID, WVALID, WLAST, RREADY, BREADY} !== 6'b0)
            $display("FAIL reset_axi_ctrl: got %b exp 000000", {ARVALID, AWVALID, WVALID, WLAST, RREADY, BREADY});
        else passed++;
        total++;
        if ({done, err, wr_ready, rd_valid, rd_last} !== 5'b0)
            $display("FAIL reset_client_ctrl: got %b exp 00000", {done, err, wr_ready, rd_valid, rd_last});
        else passed++;
        total++;
        if ({ARADDR, ARLEN, AWADDR, AWLEN} !== 80'h0)
            $display("FAIL reset_addr_len: got %h exp 0", {ARADDR, ARLEN, AWADDR, AWLEN});
        else passed++;
        rst_n = 1;
        idle_inputs();
        @(negedge clk);
        total++;
        if ({req_ready, RREADY, BREADY, rd_valid} !== 4'b1000)
            $display("FAIL idle_ignores_slave: got %b exp 1000", {req_ready, RREADY, BREADY, rd_valid});
        else passed++;
    endtask

    task automatic test_read_burst();
        @(negedge clk);
        req_valid = 1; req_write = 0; req_addr = 32'h40; req_len = 8'd7;
        ARREADY = 1; rd_ready = 1;
        @(negedge clk);
        req_valid = 0;
        total++;
        if ({ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST, req_ready} !== {1'b1, 32'h40, 8'd7, 3'd2, 2'b01, 1'b0})
            $display("FAIL read_ar: got v=%b a=%h l=%0d s=%0d b=%b rr=%b exp v=1 a=40 l=7 s=2 b=01 rr=0",
                     ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST, req_ready);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ARREADY = 0;
            RVALID = 1; RDATA = 32'h1000 + i; RLAST = (i == 7); RRESP = 2'b00;
            #1;
            total++;
            if ({rd_valid, RREADY, rd_last, rd_data, done} !== {1'b1, 1'b1, (i == 7), 32'h1000 + i, 1'b0})
                $display("FAIL read_beat%0d: got v=%b rr=%b last=%b d=%h done=%b exp v=1 rr=1 last=%b d=%h done=0",
                         i, rd_valid, RREADY, rd_last, rd_data, done, (i == 7), 32'h1000 + i);
            else passed++;
        end
        @(negedge clk);
        RVALID = 0; RLAST = 0;
        total++;
        if ({done, err, req_ready, RREADY} !== 4'b1010)
            $display("FAIL read_done: got done=%b err=%b rr=%b RREADY=%b exp 1 0 1 0", done, err, req_ready, RREADY);
        else passed++;
        @(negedge clk);
        total++;
        if (done !== 1'b0) $display("FAIL read_done_pulse: got %b exp 0", done);
        else passed++;
        rd_ready = 0;
    endtask

    task automatic test_write_burst();
        int k;
        int guard;
        @(negedge clk);
        req_valid = 1; req_write = 1; req_addr = 32'h80; req_len = 8'd3;
        AWREADY = 0;
        @(negedge clk);
        req_valid = 0;
        total++;
        if ({AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST} !== {1'b1, 32'h80, 8'd3, 3'd2, 2'b01})
            $display("FAIL write_aw: got v=%b a=%h l=%0d s=%0d b=%b exp v=1 a=80 l=3 s=2 b=01",
                     AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST);
        else passed++;
        @(negedge clk);
        AWREADY = 1;
        total++;
        if ({AWVALID, AWADDR, WVALID} !== {1'b1, 32'h80, 1'b0})
            $display("FAIL write_aw_hold: got v=%b a=%h wv=%b exp v=1 a=80 wv=0", AWVALID, AWADDR, WVALID);
        else passed++;
        k = 0; guard = 0;
        while (k < 4 && guard < 20) begin
            @(negedge clk);
            AWREADY = 0;
            wr_valid = 1; wr_data = 32'hA0 + k;
            WREADY = guard[0];
            #1;
            total++;
            if ({WVALID, WDATA, WLAST, wr_ready, BREADY} !== {1'b1, 32'hA0 + k, (k == 3), WREADY, 1'b0})
                $display("FAIL write_beat%0d: got wv=%b d=%h last=%b wr=%b br=%b exp wv=1 d=%h last=%b wr=%b br=0",
                         k, WVALID, WDATA, WLAST, wr_ready, BREADY, 32'hA0 + k, (k == 3), WREADY);
            else passed++;
            if (WREADY) k++;
            guard++;
        end
        total++;
        if (k != 4) $display("FAIL write_beats_timeout: got %0d beats exp 4", k);
        else passed++;
        @(negedge clk);
        WREADY = 1;
        #1;
        total++;
        if ({BREADY, WVALID, wr_ready, done} !== 4'b1000)
            $display("FAIL write_wresp: got br=%b wv=%b wr=%b done=%b exp 1 0 0 0", BREADY, WVALID, wr_ready, done);
        else passed++;
        BVALID = 1; BRESP = 0;
        @(negedge clk);
        BVALID = 0; wr_valid = 0; WREADY = 0;
        total++;
        if ({done, err, BREADY, req_ready} !== 4'b1001)
            $display("FAIL write_done: got done=%b err=%b br=%b rr=%b exp 1 0 0 1", done, err, BREADY, req_ready);
        else passed++;
    endtask

    task automatic test_read_len0_err();
        @(negedge clk);
        req_valid = 1; req_write = 0; req_addr = 32'h10; req_len = 8'd0;
        ARREADY = 1; rd_ready = 1;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        ARREADY = 0;
        RVALID = 1; RDATA = 32'hDEAD; RLAST = 1; RRESP = 2'b10;
        #1;
        total++;
        if ({rd_valid, rd_last, rd_data} !== {1'b1, 1'b1, 32'hDEAD})
            $display("FAIL len0_beat: got v=%b last=%b d=%h exp 1 1 0000dead", rd_valid, rd_last, rd_data);
        else passed++;
        @(negedge clk);
        RVALID = 0; RLAST = 0; RRESP = 2'b00;
        total++;
        if ({done, err} !== 2'b11) $display("FAIL len0_err: got done=%b err=%b exp 1 1", done, err);
        else passed++;
        rd_ready = 0;
    endtask

    task automatic test_back_to_back();
        BVALID = 1; BRESP = 0;
        @(negedge clk);
        req_valid = 1; req_write = 1; req_addr = 32'h200; req_len = 8'd0;
        AWREADY = 1; WREADY = 1; wr_valid = 1; wr_data = 32'h55;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        total++;
        if ({WVALID, WLAST, BREADY} !== 3'b110)
            $display("FAIL b2b_len0_wlast: got wv=%b last=%b br=%b exp 1 1 0", WVALID, WLAST, BREADY);
        else passed++;
        @(negedge clk);
        total++;
        if (BREADY !== 1'b1) $display("FAIL b2b_bready: got %b exp 1", BREADY);
        else passed++;
        @(negedge clk);
        total++;
        if ({done, err, req_ready} !== 3'b101)
            $display("FAIL b2b_done: got done=%b err=%b rr=%b exp 1 0 1", done, err, req_ready);
        else passed++;
        req_valid = 1; req_write = 1; req_addr = 32'h300; req_len = 8'd1;
        @(negedge clk);
        req_valid = 0;
        total++;
        if ({AWVALID, AWADDR, AWLEN, done} !== {1'b1, 32'h300, 8'd1, 1'b0})
            $display("FAIL b2b_accept: got v=%b a=%h l=%0d done=%b exp 1 300 1 0", AWVALID, AWADDR, AWLEN, done);
        else passed++;
        @(negedge clk);
        total++;
        if ({WVALID, WLAST} !== 2'b10) $display("FAIL b2b_beat0: got wv=%b last=%b exp 1 0", WVALID, WLAST);
        else passed++;
        @(negedge clk);
        total++;
        if ({WVALID, WLAST} !== 2'b11) $display("FAIL b2b_beat1: got wv=%b last=%b exp 1 1", WVALID, WLAST);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({done, err} !== 2'b10) $display("FAIL b2b_done2: got done=%b err=%b exp 1 0", done, err);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_last_chk();
        int  nbeats;
        logic exp_err;
`ifdef AXI_BURST_MASTER_LAST_CHK_EN
        nbeats = 4; exp_err = 1'b1;
`else
        nbeats = 3; exp_err = 1'b0;
`endif
        @(negedge clk);
        req_valid = 1; req_write = 0; req_addr = 32'h400; req_len = 8'd3;
        ARREADY = 1; rd_ready = 1;
        @(negedge clk);
        req_valid = 0;
        for (int i = 0; i < nbeats; i++) begin
            @(negedge clk);
            ARREADY = 0;
            RVALID = 1; RDATA = 32'h70 + i; RLAST = (i == 2); RRESP = 2'b00;
            #1;
            total++;
            if ({rd_valid, done} !== 2'b10)
                $display("FAIL lastchk_beat%0d: got v=%b done=%b exp 1 0", i, rd_valid, done);
            else passed++;
        end
        @(negedge clk);
        RVALID = 0; RLAST = 0;
        total++;
        if ({done, err} !== {1'b1, exp_err})
            $display("FAIL lastchk_done: got done=%b err=%b exp 1 %b", done, err, exp_err);
        else passed++;
        rd_ready = 0;
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        req_valid = 1; req_write = 1; req_addr = 32'h600; req_len = 8'd3;
        AWREADY = 1; WREADY = 1; wr_valid = 1;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        AWREADY = 0;
        @(negedge clk);
        #1;
        total++;
        if ({WVALID, WLAST} !== 2'b10) $display("FAIL rst_mid_pre: got wv=%b last=%b exp 1 0", WVALID, WLAST);
        else passed++;
        @(negedge clk);
        rst_n = 0;
        #1;
        total++;
        if ({WVALID, wr_ready, WLAST, BREADY, AWVALID, req_ready} !== 6'b000001)
            $display("FAIL rst_mid_ctrl: got %b exp 000001", {WVALID, wr_ready, WLAST, BREADY, AWVALID, req_ready});
        else passed++;
        total++;
        if ({AWADDR, AWLEN, done, err} !== 42'h0)
            $display("FAIL rst_mid_regs: got a=%h l=%0d done=%b err=%b exp 0", AWADDR, AWLEN, done, err);
        else passed++;
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if ({done, req_ready} !== 2'b01)
                $display("FAIL rst_mid_after%0d: got done=%b rr=%b exp 0 1", i, done, req_ready);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_read_burst();
        test_write_burst();
        test_read_len0_err();
        test_back_to_back();
        test_last_chk();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

endmodule

// File: doc/axi_burst_master.md
# axi_burst_master

Burst-capable AXI4 initiator that turns a simple one-outstanding request interface (CPU/cache line fill and writeback) into AXI read and write bursts. It drives the read address/data and write address/data/response channels of any slave in the design, including the on-chip memory slave. It handles one transaction at a time: INCR bursts of up to 256 beats, with per-transaction completion and error reporting.

## Interface
- ADDR_WIDTH, 32, address width on request and AXI sides
- DATA_WIDTH, 32, data bus width; 32 or 64 only
- LEN_WIDTH, 8, width of AxLEN and req_len (beats−1)
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid / req_ready  in/out  1  request handshake; req_ready=1 only in IDLE
- req_write  in  1  1=write burst, 0=read burst
- req_addr  in  ADDR_WIDTH  byte start address, DATA_WIDTH-aligned
- req_len  in  LEN_WIDTH  beats−1
- wr_valid / wr_ready  in/out  1  write-data stream from client
- wr_data  in  DATA_WIDTH  write beat
- rd_valid / rd_ready  out/in  1  read-data stream to client
- rd_data  out  DATA_WIDTH  read beat; rd_last  out  1  final beat
- done  out  1  one-cycle completion pulse; err  out  1  valid with done
- ARVALID, ARREADY, ARADDR, ARLEN, ARSIZE, ARBURST: AXI read address (out,in,out,out,out,out; widths 1,1,ADDR_WIDTH,LEN_WIDTH,3,2)
- RVALID in 1, RREADY out 1, RDATA in DATA_WIDTH, RLAST in 1, RRESP in 2
- AWVALID, AWREADY, AWADDR, AWLEN, AWSIZE, AWBURST: mirror of AR group
- WVALID out 1, WREADY in 1, WDATA out DATA_WIDTH, WLAST out 1
- BVALID in 1, BREADY out 1, BRESP in 1 (1=error)

## Operation
- FSM: IDLE → (req_valid, !req_write) RADDR → RDATA → IDLE; IDLE → (req_valid, req_write) WADDR → WDATA → WRESP → IDLE.
- Request accept in IDLE: latch addr/len/write, clear beat counter and err accumulator.
- RADDR/WADDR: ARVALID/AWVALID=1 with latched fields, held stable until xREADY; ARSIZE/AWSIZE=log2(DATA_WIDTH/8); ARBURST/AWBURST=2'b01 (INCR).
- RDATA: RREADY=rd_ready, rd_valid=RVALID, rd_data=RDATA, rd_last=RLAST (combinational pass-through). Per beat err |= (RRESP!=0). Leave on handshake with RLAST=1.
- WDATA: WVALID=wr_valid, WDATA=wr_data, wr_ready=WREADY (combinational, only in WDATA). WLAST=(beat_cnt==len). Counter increments per W handshake; leave on last handshake.
- WRESP: BREADY=1; on BVALID err |= BRESP, go IDLE.
- Final handshake (RLAST beat / B) sets done=1 next cycle with accumulated err; FSM already in IDLE, so new request accepted in done cycle.
- Outside their states all AXI valid/ready outputs and wr_ready/rd_valid are 0.

## Timing
- Reset: state IDLE; ARVALID, AWVALID, WVALID, WLAST, RREADY, BREADY, done, err, wr_ready, rd_valid, rd_last=0; req_ready=1; address/len outputs 0.
- Req accept at edge N → xVALID high in cycle N+1. xREADY already high → address phase 1 cycle.
- Read/write data: zero added latency, full throughput (1 beat/cycle).
- len=0: single beat, WLAST=1 on first beat.
- reset mid-burst: immediate abandon, outputs to reset values; slave shares rst_n.
- RVALID/BVALID outside expected state: ignored (ready=0).

## Configuration
- AXI_BURST_MASTER_LAST_CHK_EN defined: read beats counted; RLAST on beat≠len, or missing RLAST on beat==len, sets err; burst terminates on counter at beat len. Undefined: no read counter, termination solely on RLAST, err from RRESP only.

## Structure
- Package axi_pkg: AXI_BURST_INCR=2'b01, RESP_OKAY=2'b00, state enum, size-from-width function.
- One sub-module: axi_beat_counter (clear, inc, len compare → is_last), used for W and, under the macro, R.

## Test plan
- Read, addr 0x40, len 7, slave RVALID every cycle → ARLEN=7, ARSIZE=2, 8 rd beats, rd_last on 8th, done next cycle, err=0.
- Write, addr 0x80, len 3, data 0xA0..0xA3, WREADY toggling → exactly 4 W beats, WLAST on 0xA3 only, BREADY then done, err=0.
- Read len 0 with RRESP=2'b10 → single beat, done with err=1.
- Back-to-back: write request held valid during done cycle → accepted in done cycle, AWVALID next cycle.
- Macro on: read len 3, slave RLAST on beat 2 → err=1 at done; macro off → burst ends at beat 2, err=0.
- rst_n low in WDATA after 2 beats → all outputs reset asynchronously, req_ready=1 after release, no done.
